// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// Module   : uart_rx_deserializer
// Function : Oversampling UART receiver; majority-voted bits, optional parity,
//            one stop bit, registered valid/error strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_EDGE_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] c_SMP_FIRST = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] c_SMP_LAST  = CNT_W'(PRESCALE / 2 + 1);
    localparam logic [CNT_W-1:0] c_DECIDE    = CNT_W'(PRESCALE / 2 + 2);
    localparam logic [BIT_W-1:0] c_BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]            state_q,      state_d;
    logic [CNT_W-1:0]      edge_cnt_q,   edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [2:0]            smp_q,        smp_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic                  par_en_q,     par_en_d;
    logic                  par_typ_q,    par_typ_d;
    logic                  par_bad_q,    par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q,    par_err_d;
    logic                  stp_err_q,    stp_err_d;

    logic maj_bit;
    logic edge_last;
    logic edge_decide;

    assign maj_bit     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign edge_last   = (edge_cnt_q == c_EDGE_LAST);
    assign edge_decide = (edge_cnt_q == c_DECIDE);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_last ? '0 : edge_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        smp_d        = smp_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != c_ST_IDLE && edge_cnt_q >= c_SMP_FIRST && edge_cnt_q <= c_SMP_LAST) begin
            smp_d = {smp_q[1:0], RX_IN};
        end

        case (state_q)
            c_ST_IDLE: begin
                edge_cnt_d = '0;
                // The detecting cycle is oversample 0 of the start bit.
                if (!RX_IN) begin
                    state_d    = c_ST_START;
                    edge_cnt_d = CNT_W'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            c_ST_START: begin
                if (edge_decide && maj_bit) begin
                    state_d    = c_ST_IDLE;
                    edge_cnt_d = '0;
                end else if (edge_last) begin
                    state_d = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (edge_decide) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = maj_bit;
                end
                if (edge_last) begin
                    if (bit_cnt_q == c_BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? c_ST_PARITY : c_ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            c_ST_PARITY: begin
                if (edge_decide) begin
                    par_bad_d = maj_bit ^ (^shift_q) ^ par_typ_q;
                end
                if (edge_last) begin
                    state_d = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                // Stop majority is still held from samples taken mid-bit.
                if (edge_last) begin
                    state_d = c_ST_IDLE;
                    if (!maj_bit) begin
                        stp_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = c_ST_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= c_ST_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            smp_q        <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            smp_q        <= smp_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

`default_nettype wire

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive path: the counterpart of the UART transmit serializer.
- Oversamples a synchronous serial line and detects a start bit.
- Recovers DATA_WIDTH data bits LSB first, then an optional parity bit and one stop bit.
- Presents the word in parallel with a one-cycle valid strobe.
- Sits between the upstream RX_IN synchronizer and the register/FIFO interface.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (LSB first)
PRESCALE, 8, Clk cycles per bit (oversampling ratio); legal values 8, 16, 32

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous, active-low reset
RX_IN  input  1  serial line, idle high, already synchronous to Clk
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last correctly received word
data_valid  output  1  one-cycle strobe: P_DATA updated with a good frame
par_err  output  1  one-cycle strobe: parity mismatch, frame dropped
stp_err  output  1  one-cycle strobe: stop bit sampled 0, frame dropped

Behaviour:
- Reset (Reset low, async): all outputs 0, P_DATA = 0, FSM in IDLE, counters 0. A reset mid-frame discards the frame with no strobe.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 and wraps at each bit boundary.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: the first cycle RX_IN = 0 is oversample 0 of the start bit. Go to START with edge_cnt = 1. Latch PAR_EN and PAR_TYP in this cycle; they are stable for the rest of the frame.
- Bit sampling:
  - Each bit is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the 2-of-3 majority.
  - The decision is available at edge_cnt = PRESCALE/2+2.
- START:
  - Majority 1 (glitch): return to IDLE at the decision cycle. No strobe, no output change.
  - Otherwise go to DATA when edge_cnt = PRESCALE-1.
- DATA:
  - Shift the majority bit into the shift register, LSB first.
  - After bit DATA_WIDTH-1 ends (edge_cnt = PRESCALE-1), go to PARITY if PAR_EN, else to STOP.
- PARITY:
  - Expected parity bit = XOR of data bits (even), or its inverse (odd).
  - Record a mismatch flag.
  - Go to STOP at edge_cnt = PRESCALE-1.
- STOP, evaluated at edge_cnt = PRESCALE-1, then go to IDLE:
  - Stop majority 0: stp_err pulses next cycle.
  - Else parity mismatch: par_err pulses next cycle.
  - Else P_DATA loads the shift register and data_valid pulses next cycle.
- Error priority: stp_err overrides par_err; at most one strobe per frame. On error P_DATA holds its previous value.
- Latency: with start oversample 0 at cycle T, the strobe is at cycle T + (2 + DATA_WIDTH + PAR_EN) × PRESCALE.
  - 8N1, PRESCALE 8: T+80.
  - With parity: T+88.
- Back-to-back frames: IDLE may detect the next start bit in the strobe cycle itself, so zero idle bits between frames are supported.
- Break / line stuck low: each frame period ends in stp_err, and detection restarts immediately. No lock-up.
- Strobes are registered, never combinational from RX_IN.

Test Plan:
1. Prescale and latency: 8N1, PRESCALE 8, send 0xA5 (LSB first), start at T → data_valid high only at T+80, P_DATA = 0xA5, par_err = stp_err = 0. Repeat with PRESCALE 16 → strobe at T+160.
2. Even parity: PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 → data_valid at T+88, P_DATA = 0x3C. Then 0x3D with parity bit 0 → par_err pulse at T+88, no data_valid, P_DATA stays 0x3C.
3. Odd parity plus error priority:
   - PAR_TYP=1, 0x01 with parity bit 0 → valid, P_DATA = 0x01.
   - Frame with both bad parity and stop bit 0 → only stp_err pulses.
4. Glitch and majority filtering:
   - RX_IN low for 2 cycles only → stays IDLE, no strobe.
   - Data bit with a 1-cycle inverted spike at oversample 3 → majority gives the correct bit, 0x55 received.
5. Stop error and back-to-back: 0x0F with stop bit 0 → stp_err at T+80, no data_valid. Then two frames 0x12, 0x34 with zero idle bits → strobes at T+80 and T+160 with P_DATA 0x12 then 0x34.
6. Reset mid-frame: assert Reset during data bit 4 of 0xC3 → all outputs 0 immediately, no strobe. After release, a clean frame 0xFF → data_valid with P_DATA = 0xFF.
